// File: rtl/chunked_addsub_seq.sv
// rtl/chunked_addsub_seq.sv - multi-cycle chunked adder/subtractor with valid/ready handshakes
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, sub, cin captured on accept)
//   a, b                 WIDTH-bit operands
//   sub                  0 = a + b + cin, 1 = a - b - cin
//   cin                  carry-in for add, borrow-in for subtract
//   out_valid / out_ready result handshake
//   sum                  WIDTH-bit result, held until the next operation writes it
//   cout                 carry out of the top bit (for subtract: 1 = no borrow)
//   ovf                  signed two's-complement overflow
//   zero                 sum == 0
module chunked_addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Operands and result viewed as NCHUNK slices of CHUNK bits each.
  logic [NCHUNK-1:0][CHUNK-1:0] a_q;
  logic [NCHUNK-1:0][CHUNK-1:0] b_q;
  logic [NCHUNK-1:0][CHUNK-1:0] sum_q;
  logic [NCHUNK-1:0][CHUNK-1:0] sum_next;

  logic [IDXW-1:0] idx;
  logic            carry;
  logic            cout_q;
  logic            ovf_q;
  logic            zero_q;

  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK-1:0] s_k;
  logic             c_k;
  logic             msb_cin;
  logic             last;

  // One narrow CHUNK-bit adder shared across all cycles.
  always_comb begin
    a_k      = a_q[idx];
    b_k      = b_q[idx];
    {c_k, s_k} = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry};
    // Carry into the MSB is recovered from the MSB sum bit; only meaningful
    // on the final chunk, where it feeds the overflow flag.
    msb_cin  = s_k[CHUNK-1] ^ a_k[CHUNK-1] ^ b_k[CHUNK-1];
    sum_next = sum_q;
    sum_next[idx] = s_k;
    last     = (idx == IDXW'(NCHUNK - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            // Subtract is A + ~B + 1; borrow-in cancels that +1.
            b_q   <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_q <= sum_next;
          carry <= c_k;
          if (last) begin
            cout_q <= c_k;
            ovf_q  <= msb_cin ^ c_k;
            zero_q <= (sum_next == '0);
            idx    <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_addsub_seq.sv
// tb/tb_chunked_addsub_seq.sv - self-checking bench for chunked_addsub_seq
module tb_chunked_addsub_seq;

  localparam int W = 32;
  localparam int C = 4;
  localparam int N = W / C;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0]  a, b, sum;

  logic          in_valid8, in_ready8, sub8, cin8, out_valid8, out_ready8, cout8, ovf8, zero8;
  logic [7:0]    a8, b8, sum8;

  chunked_addsub_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  chunked_addsub_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: wide add, overflow from operand/result sign bits.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic s, input logic ci);
    exp_t        r;
    logic [31:0] beff;
    logic [32:0] full;
    beff   = s ? ~bv : bv;
    full   = {1'b0, av} + {1'b0, beff} + {32'd0, ci ^ s};
    r.sum  = full[31:0];
    r.cout = full[32];
    r.ovf  = (av[31] == beff[31]) && (full[31] != av[31]);
    r.zero = (full[31:0] == 32'd0);
    return r;
  endfunction

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic s,
                        input logic ci, input exp_t e, input int hold);
    int          lat;
    exp_t        got_e;
    logic [31:0] held;
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("in_ready_idle", in_ready, 1);
    a = av; b = bv; sub = s; cin = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(e);
    a = $urandom; b = $urandom; sub = ~s; cin = ~ci;
    check("in_ready_run", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, N);
    held = sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check("hold_sum", sum, held);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty got 0 entries expected 1");
      got_e = e;
    end else begin
      got_e = sb.pop_front();
      check("sum", sum, got_e.sum);
      check("cout", cout, got_e.cout);
      check("ovf", ovf, got_e.ovf);
      check("zero", zero, got_e.zero);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_sum_kept", sum, got_e.sum);
    check("post_cout_kept", cout, got_e.cout);
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    vecs[0] = '{32'h0000000F, 32'h00000001, 1'b0, 1'b0, '{32'h00000010, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0}};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
    vecs[5] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, '{32'h00000006, 1'b1, 1'b0, 1'b0}};
    vecs[6] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    vecs[7] = '{32'h00001234, 32'h00001234, 1'b1, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}};

    rst = 1'b1;
    in_valid = 0; out_ready = 0; a = 0; b = 0; sub = 0; cin = 0;
    in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; sub8 = 0; cin8 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_flags", {cout, ovf, zero}, 0);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, vecs[i].e, 0);

    // Backpressure in DONE, then back-to-back second operation.
    run_op(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b0, model(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b0), 5);
    run_op(32'h00000003, 32'h00000009, 1'b1, 1'b1, model(32'h00000003, 32'h00000009, 1'b1, 1'b1), 0);

    // Reset three chunks into an operation that would carry through every chunk.
    a = 32'hFFFFFFFF; b = 32'h00000001; sub = 0; cin = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_flags", {cout, ovf, zero}, 0);
    check("abort_in_ready_rst", in_ready, 0);
    rst = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    run_op(32'h00000000, 32'h00000000, 1'b0, 1'b0, '{32'h00000000, 1'b0, 1'b0, 1'b1}, 0);
    run_op(32'h00000021, 32'h00000001, 1'b0, 1'b0, '{32'h00000022, 1'b0, 1'b0, 1'b0}, 0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      logic        rs, rc;
      ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
      run_op(ra, rb, rs, rc, model(ra, rb, rs, rc), i % 2);
    end

    // Single-chunk configuration.
    a8 = 8'h80; b8 = 8'h80; sub8 = 0; cin8 = 0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("w8_latency", lat, 1);
    check("w8_sum", sum8, 8'h00);
    check("w8_cout", cout8, 1);
    check("w8_ovf", ovf8, 1);
    check("w8_zero", zero8, 1);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("w8_post_out_valid", out_valid8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunked_addsub_seq.md
Name: chunked_addsub_seq

Overview:
Parametrised multi-cycle adder/subtractor. Processes WIDTH-bit operands CHUNK bits per cycle, holding the carry in a register between chunks. Supports add, subtract and borrow-in modes, and reports carry, signed-overflow and zero flags. Valid/ready handshakes on both sides let it sit between an operand source and a result consumer in the datapath, trading latency for a narrow carry chain.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 1.
CHUNK, 4, bits added per cycle; must divide WIDTH exactly. CHUNK == WIDTH is legal (single-cycle compute).
NCHUNK, WIDTH/CHUNK, derived localparam; number of compute cycles.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand source has a valid request
in_ready  output  1  block can accept a request
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = add, 1 = subtract
cin  input  1  carry-in (add) / borrow-in (sub)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  final carry out of bit WIDTH-1
ovf  output  1  signed two's-complement overflow
zero  output  1  sum == 0

Behaviour:
- Reset, sampled on clk edge while rst=1:
  - state IDLE; chunk index 0; carry register 0.
  - sum=0, cout=0, ovf=0, zero=0, out_valid=0.
  - in_ready=0 while rst=1; in_ready=1 from the first cycle after rst deasserts.
  - Reset mid-operation aborts the operation; no partial result is ever presented.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> RUN on in_valid & in_ready. At that edge:
  - latch a, and b XOR {WIDTH{sub}} as the effective B operand.
  - carry register <= cin ^ sub.
  - chunk index <= 0.
  - Resulting operations: add gives A+B+cin; sub with cin=0 gives A-B; sub with cin=1 gives A-B-1.
- RUN, each cycle at chunk index k:
  - sum[k*CHUNK +: CHUNK] <= A_k + Beff_k + carry.
  - carry <= chunk carry-out; k <= k+1.
  - When k == NCHUNK-1: cout <= final carry out; ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; zero computed on the complete sum; state <= DONE.
- Latency: out_valid first high exactly NCHUNK cycles after the accepting edge.
- DONE -> IDLE on out_ready=1. sum and flags stay stable throughout DONE. After the handoff, sum and flags retain their values but out_valid=0.
- in_valid is ignored in RUN and DONE; operand inputs may change freely after acceptance.
- Peak throughput: one result per NCHUNK+2 cycles (accept, NCHUNK compute, one DONE cycle with out_ready=1).
- Subtract flags: cout=1 means no borrow (A >= B + cin, unsigned).
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
(WIDTH=32, CHUNK=4, NCHUNK=8 unless stated)
- Add a=0x0000000F, b=0x00000001, sub=0, cin=0 -> out_valid 8 cycles after accept; sum=0x00000010, cout=0, ovf=0, zero=0.
- Add a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0, zero=1. Repeat with a=0x7FFFFFFF -> sum=0x80000000, cout=0, ovf=1.
- Subtract 5-7 (sub=1, cin=0) -> sum=0xFFFFFFFE, cout=0, ovf=0. Subtract 0x80000000-1 -> sum=0x7FFFFFFF, cout=1, ovf=1. Subtract 10-3 with cin=1 -> sum=0x00000006, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle in_valid/a/b -> sum and flags stable, in_ready=0, no new accept. Release out_ready -> in_ready=1 the next cycle; second operation accepted and correct.
- Reset mid-RUN after 3 chunks -> cycle after the rst edge: out_valid=0, sum=0, flags=0; in_ready=1 once rst drops; the next operation computes correctly with no stale carry.
- Config WIDTH=8, CHUNK=8: a=0x80, b=0x80 add -> out_valid 1 cycle after accept; sum=0x00, cout=1, ovf=1, zero=1.
